// File: rtl/md_sequencer.sv
// Iterative RV64M multiply/divide sequencer for the execute stage.
// Radix-2 shift-add multiply, restoring shift-subtract divide, one bit per cycle.
// Optional feature macro: MD_EARLY_OUT_EN (multiply exits CALC once the
// remaining multiplier bits are all zero).
module md_sequencer #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  logic            flush,
  input  logic [2:0]      func,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] c
);

  localparam int unsigned HW = 32;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-HW+1){1'b1}}, {(HW-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;    // product, or partial remainder in [XLEN:0]
  logic [2*XLEN-1:0] opa_q, opa_d;    // shifted multiplicand, or divisor in low half
  logic [XLEN-1:0]   opb_q, opb_d;    // multiplier, or dividend/quotient shift reg
  logic              is_div_q, is_div_d;
  logic [1:0]        msel_q, msel_d;
  logic              word_q, word_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic              special_q, special_d;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   c_q, c_d;

  logic              f_div, a_sgn, b_sgn, neg_a, neg_b, dz, ovf, early_c;
  logic [1:0]        msel_in;
  logic [XLEN-1:0]   ea, eb, mag_a, mag_b, a_w, dvd_res, sp_res, fix_res;
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   res_raw;

  assign busy  = busy_q;
  assign done  = done_q;
  assign c     = c_q;
  assign stall = valid & ~done_q;

`ifdef MD_EARLY_OUT_EN
  assign early_c = ~is_div_q & ((opb_q >> 1) == '0);
`else
  assign early_c = 1'b0;
`endif

  // Operand decode: extension, magnitudes, result signs and special cases.
  always_comb begin
    f_div   = func[2];
    msel_in = word ? 2'd0 : func[1:0];
    a_sgn   = f_div ? ~func[0] : ((msel_in == 2'd1) || (msel_in == 2'd2));
    b_sgn   = f_div ? ~func[0] : (msel_in == 2'd1);
    ea      = a;
    eb      = b;
    if (word) begin
      ea = a_sgn ? {{(XLEN-HW){a[HW-1]}}, a[HW-1:0]} : {{(XLEN-HW){1'b0}}, a[HW-1:0]};
      eb = b_sgn ? {{(XLEN-HW){b[HW-1]}}, b[HW-1:0]} : {{(XLEN-HW){1'b0}}, b[HW-1:0]};
    end
    neg_a   = a_sgn & ea[XLEN-1];
    neg_b   = b_sgn & eb[XLEN-1];
    mag_a   = neg_a ? -ea : ea;
    mag_b   = neg_b ? -eb : eb;
    a_w     = {{(XLEN-HW){a[HW-1]}}, a[HW-1:0]};
    dvd_res = word ? a_w : a;
    dz      = f_div & (eb == '0);
    ovf     = f_div & ~func[0] & (ea == (word ? MIN_W : MIN_X)) & (&eb);
    if (dz) sp_res = func[1] ? dvd_res : '1;
    else    sp_res = func[1] ? '0 : dvd_res;
  end

  // Final result: sign correction, half/quotient/remainder select, W extension.
  always_comb begin
    prod = negq_q ? -acc_q : acc_q;
    if (special_q) begin
      res_raw = acc_q[XLEN-1:0];
    end else if (is_div_q) begin
      if (msel_q[1]) res_raw = negr_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      else           res_raw = negq_q ? -opb_q : opb_q;
    end else begin
      res_raw = (msel_q == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
    fix_res = word_q ? {{(XLEN-HW){res_raw[HW-1]}}, res_raw[HW-1:0]} : res_raw;
  end

  // Next-state and datapath iteration.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    msel_d    = msel_q;
    word_d    = word_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    special_d = special_q;
    c_d       = c_q;
    rem_sh    = {acc_q[XLEN-1:0], opb_q[XLEN-1]};
    diff      = {1'b0, rem_sh} - {2'b00, opa_q[XLEN-1:0]};
    case (state_q)
      S_IDLE: begin
        if (valid) begin
          is_div_d  = f_div;
          msel_d    = f_div ? func[1:0] : msel_in;
          word_d    = word;
          negq_d    = neg_a ^ neg_b;
          negr_d    = neg_a;
          cnt_d     = word ? CNT_W'(HW) : CNT_W'(XLEN);
          special_d = dz | ovf;
          if (dz || ovf) begin
            acc_d   = {{XLEN{1'b0}}, sp_res};
            state_d = S_FIX;
          end else begin
            acc_d   = '0;
            state_d = S_CALC;
            if (f_div) begin
              opa_d = {{XLEN{1'b0}}, mag_b};
              opb_d = word ? {mag_a[HW-1:0], {(XLEN-HW){1'b0}}} : mag_a;
            end else begin
              opa_d = {{XLEN{1'b0}}, mag_a};
              opb_d = mag_b;
            end
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (is_div_q) begin
          if (!diff[XLEN+1]) acc_d = {{(XLEN-1){1'b0}}, diff[XLEN:0]};
          else               acc_d = {{(XLEN-1){1'b0}}, rem_sh};
          opb_d = {opb_q[XLEN-2:0], ~diff[XLEN+1]};
        end else begin
          if (opb_q[0]) acc_d = acc_q + opa_q;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end
        if ((cnt_q == CNT_W'(1)) || early_c) state_d = S_FIX;
      end
      S_FIX: begin
        c_d     = fix_res;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      c_d     = c_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      msel_q    <= '0;
      word_q    <= 1'b0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      special_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      c_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      msel_q    <= msel_d;
      word_q    <= word_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      special_q <= special_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      c_q       <= c_d;
    end
  end

  // The pipeline must hold valid for the whole op unless it flushes.
  a_valid_held: assert property (@(posedge clk) disable iff (reset)
    ((state_q == S_CALC) || (state_q == S_FIX)) |-> (valid || flush));

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: results, latency, stall/busy/done timing, flush.
module tb_md_sequencer;

`ifdef MD_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, valid, flush, word;
  logic [2:0]  func;
  logic [63:0] a, b, c;
  logic        busy, stall, done;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  md_sequencer #(.XLEN(64), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .valid(valid), .flush(flush), .func(func),
    .word(word), .a(a), .b(b), .busy(busy), .stall(stall), .done(done), .c(c)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; that cycle is the accept cycle (cycle 0).
  task automatic run_op(input string tag, input logic [2:0] f, input logic w,
                        input logic [63:0] av, input logic [63:0] bv, input logic [63:0] ev,
                        input int lat_full, input int lat_early);
    int cyc;
    int stall_bad;
    int lat;
    lat       = EARLY ? lat_early : lat_full;
    func      = f;
    word      = w;
    a         = av;
    b         = bv;
    valid     = 1'b1;
    flush     = 1'b0;
    cyc       = 0;
    stall_bad = 0;
    while (cyc <= 200) begin
      @(negedge clk);
      if (done) break;
      if (!stall) stall_bad++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, ".lat"}, 64'(cyc), 64'(lat));
    chk({tag, ".c"}, c, ev);
    chk({tag, ".busy_done"}, 64'(busy), 64'd1);
    chk({tag, ".stall_done"}, 64'(stall), 64'd0);
    chk({tag, ".stall_wait"}, 64'(stall_bad), 64'd0);
    @(posedge clk);
    #1;
    valid = 1'b0;
    chk({tag, ".done_pulse"}, 64'(done), 64'd0);
    chk({tag, ".busy_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int seen;
    reset = 1'b1; valid = 1'b0; flush = 1'b0; func = 3'd0; word = 1'b0;
    a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.c", c, 64'd0);
    chk("rst.stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;

    run_op("mul",     3'd0, 1'b0, 64'd7, 64'd6, 64'd42, 66, 5);
    run_op("div",     3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66, 66);
    run_op("rem",     3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66, 66);
    run_op("divw_ov", 3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 2, 2);
    run_op("divu_z",  3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 2);
    run_op("remu_z",  3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 2, 2);
    run_op("mulhu",   3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, 66, 66);
    run_op("mulh",    3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 66, 3);
    run_op("mulhsu",  3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 4);
    run_op("mulw",    3'd0, 1'b1, 64'hABCD_0000_0000_8000, 64'h0000_0000_0001_0000,
           64'hFFFF_FFFF_8000_0000, 34, 19);
    run_op("divu",    3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 66, 66);
    run_op("remu",    3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 66, 66);
    run_op("divw",    3'd4, 1'b1, 64'h1234_5678_FFFF_FFF0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 34, 34);
    run_op("remuw",   3'd7, 1'b1, 64'hDEAD_0000_FFFF_FFFF, 64'h10, 64'hF, 34, 34);
    run_op("divuw",   3'd5, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 34, 34);
    run_op("div_ov",  3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 2, 2);
    run_op("rem_ov",  3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2, 2);
    run_op("remw_z",  3'd6, 1'b1, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 2, 2);

    // valid together with flush must not start an op
    func = 3'd4; word = 1'b0; a = 64'd9; b = 64'd3; valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0; flush = 1'b0;
    chk("vflush.busy", 64'(busy), 64'd0);

    // flush in cycle 10 of a DIV, then a new op in cycle 11
    func = 3'd4; word = 1'b0; a = 64'hFFFF_FFFF_FFFF_FFEC; b = 64'd3; valid = 1'b1; flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) seen++;
      @(posedge clk);
      #1;
    end
    chk("flush.busy_pre", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    if (done) seen++;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush.busy", 64'(busy), 64'd0);
    chk("flush.done", 64'(done), 64'd0);
    chk("flush.c_kept", c, 64'hFFFF_FFFF_8000_0001);
    chk("flush.no_pulse", 64'(seen), 64'd0);
    run_op("post_flush", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 66, 66);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
